// File: rtl/static_ram.sv
// 64x8 single-port synchronous RAM with a shared tri-state data bus.
// Optional power-on clear sweep enabled by defining STATIC_RAM_CLEAR_EN.
module static_ram #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_ce,
    input  logic              i_rw,
    input  logic [ADDR_W-1:0] i_addr,
    inout  wire  [DATA_W-1:0] io_data,
    output logic              o_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    logic              w_busy;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;
    logic              w_host_wr;
    logic              w_host_rd;

    assign w_host_wr = i_ce & ~i_rw & ~w_busy;
    assign w_host_rd = i_ce &  i_rw & ~w_busy;

`ifdef STATIC_RAM_CLEAR_EN
    // state    | meaning
    // ST_SWEEP | writing 0x00 to r_clr_addr each cycle, host ignored
    // ST_READY | sweep done, host accesses accepted
    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_clr_addr;
    logic              r_busy;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_SWEEP;
            r_clr_addr <= '0;
            r_busy     <= 1'b1;
        end else begin
            case (r_state)
                ST_SWEEP: begin
                    r_clr_addr <= r_clr_addr + 1'b1;
                    if (r_clr_addr == '1) begin
                        r_state <= ST_READY;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_READY;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign w_busy    = r_busy;
    assign w_wr_en   = i_rst_n & (r_busy | w_host_wr);
    assign w_wr_addr = r_busy ? r_clr_addr : i_addr;
    assign w_wr_data = r_busy ? '0 : io_data;
`else
    assign w_busy    = 1'b0;
    assign w_wr_en   = i_rst_n & w_host_wr;
    assign w_wr_addr = i_addr;
    assign w_wr_data = io_data;
`endif

    // Array has no reset so it maps onto plain storage cells.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (w_host_rd) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    // Drive gating is combinational so bus turnaround follows i_ce/i_rw immediately.
    assign io_data = (i_ce && i_rw) ? r_rdata : {DATA_W{1'bz}};
    assign o_busy  = w_busy;

endmodule

// File: tb/tb_static_ram.sv
// Directed self-checking bench for static_ram; follows STATIC_RAM_CLEAR_EN if defined.
module tb_static_ram;

    logic       clk;
    logic       rst_n;
    logic       ce;
    logic       rw;
    logic [5:0] addr;
    logic [7:0] drv;
    logic       drv_en;
    logic       busy;
    wire  [7:0] w_data;

    int n_checks;
    int n_fail;

    assign w_data = drv_en ? drv : 8'bzzzz_zzzz;

    static_ram #(.ADDR_W(6), .DATA_W(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_ce    (ce),
        .i_rw    (rw),
        .i_addr  (addr),
        .io_data (w_data),
        .o_busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until busy drops; returns number of edges seen with busy high.
    task automatic wait_sweep(output int n);
        n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        ce = 1'b1; rw = 1'b0; addr = a; drv = d; drv_en = 1'b1;
        step();
    endtask

    task automatic rd(input logic [5:0] a, output logic [7:0] d);
        drv_en = 1'b0; ce = 1'b1; rw = 1'b1; addr = a;
        step();
        d = w_data;
    endtask

    logic [7:0] v;
    int         n;

    initial begin
        n_checks = 0; n_fail = 0;
        rst_n = 1'b0; ce = 1'b1; rw = 1'b1; addr = '0; drv = '0; drv_en = 1'b0;
        #2;
        chk("rst_bus", {24'd0, w_data}, 32'h00);
`ifdef STATIC_RAM_CLEAR_EN
        chk("rst_busy", {31'd0, busy}, 32'd1);
`else
        chk("rst_busy", {31'd0, busy}, 32'd0);
`endif
        step();
        step();
        rst_n = 1'b1;

`ifdef STATIC_RAM_CLEAR_EN
        // Host tries to write addr 0 throughout the sweep; it must be ignored.
        ce = 1'b1; rw = 1'b0; addr = 6'd0; drv = 8'h77; drv_en = 1'b1;
        wait_sweep(n);
        chk("sweep_len", n, 32'd64);
        rd(6'd0, v);
        chk("sweep_addr0", {24'd0, v}, 32'h00);
        rd(6'd63, v);
        chk("sweep_addr63", {24'd0, v}, 32'h00);
`endif

        for (int i = 0; i < 64; i++) begin
            ce = 1'b1; rw = 1'b0; addr = i[5:0]; drv = 8'(i + 1); drv_en = 1'b1;
            step();
            if (i == 7) chk("wr_bus_host", {24'd0, w_data}, 32'h08);
            step();
        end

        drv_en = 1'b0; ce = 1'b1; rw = 1'b1; addr = 6'd0;
        #1;
        chk("stale_rdata", {24'd0, w_data}, 32'h00);
        for (int i = 0; i < 64; i++) begin
            addr = i[5:0];
            step();
            chk($sformatf("readback_%0d", i), {24'd0, w_data}, 32'(i + 1));
        end

        drv = 8'hA5; drv_en = 1'b1;
        ce = 1'b0; rw = 1'b1; #1;
        chk("release_ce0_rd", {24'd0, w_data}, 32'hA5);
        ce = 1'b0; rw = 1'b0; #1;
        chk("release_ce0_wr", {24'd0, w_data}, 32'hA5);
        ce = 1'b1; rw = 1'b0; addr = 6'd20; #1;
        chk("release_ce1_wr", {24'd0, w_data}, 32'hA5);
        step();
        rd(6'd20, v);
        chk("write_a5", {24'd0, v}, 32'hA5);

        wr(6'd5, 8'h11);
        ce = 1'b0; rw = 1'b0; addr = 6'd5; drv = 8'hFF; drv_en = 1'b1;
        step(); step(); step();
        rd(6'd5, v);
        chk("disabled_write", {24'd0, v}, 32'h11);

        wr(6'd10, 8'h3C);
        rd(6'd10, v);
        chk("back_to_back", {24'd0, v}, 32'h3C);

        rd(6'd1, v);
        chk("pre_reset_rd", {24'd0, v}, 32'h02);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_read", {24'd0, w_data}, 32'h00);
        step();
        rst_n = 1'b1;
`ifdef STATIC_RAM_CLEAR_EN
        wait_sweep(n);
        chk("resweep_len", n, 32'd64);
        rd(6'd1, v);
        chk("post_reset_rd", {24'd0, v}, 32'h00);
`else
        rd(6'd1, v);
        chk("post_reset_rd", {24'd0, v}, 32'h02);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
